// File: rtl/wave_pkg.sv
// Shared types, wavetable contents and saturation helper for the wavetable voice mixer.
package wave_pkg;

  localparam int unsigned WAVE_TBL_DEPTH = 64;
  localparam int unsigned WAVE_SMP_W     = 16;

  typedef enum logic [1:0] {StIdle, StFetch, StAcc, StOut} wave_state_e;

  // Plucked-string cycle: silent attack, rounded positive lobe, slow negative release.
  localparam logic signed [WAVE_SMP_W-1:0] WAVE_TBL [WAVE_TBL_DEPTH] = '{
    16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0246, 16'h0612,
    16'h0A30, 16'h0E80, 16'h12C4, 16'h16F0, 16'h1B00, 16'h1EE0, 16'h2290, 16'h2500,
    16'h2700, 16'h2850, 16'h2910, 16'h2950, 16'h28F0, 16'h2825, 16'h2700, 16'h2580,
    16'h2380, 16'h2100, 16'h1E00, 16'h1A80, 16'h1690, 16'h1230, 16'h0D80, 16'h0890,
    16'h0380, 16'hFE60, 16'hF940, 16'hF430, 16'hEF50, 16'hEAB0, 16'hE670, 16'hE2A0,
    16'hDF60, 16'hDCC0, 16'hDAD0, 16'hD9A0, 16'hD930, 16'hD990, 16'hDA40, 16'hDB20,
    16'hDC00, 16'hDC90, 16'hDD00, 16'hDDA0, 16'hDF00, 16'hE100, 16'hE380, 16'hE680,
    16'hE9E0, 16'hED80, 16'hF100, 16'hF460, 16'hF720, 16'hF900, 16'hFA10, 16'hFAA7
  };

  function automatic logic signed [15:0] sat16(input logic signed [31:0] v);
    if (v > 32'sd32767) begin
      return 16'sh7FFF;
    end else if (v < -32'sd32768) begin
      return 16'sh8000;
    end else begin
      return v[15:0];
    end
  endfunction

endpackage

// File: rtl/wave_rom_string.sv
// Combinational lookup into the shared string-timbre wavetable.
module wave_rom_string
  import wave_pkg::*;
(
  input  logic        [5:0]            idx_i,
  output logic signed [WAVE_SMP_W-1:0] smp_o
);

  assign smp_o = WAVE_TBL[idx_i];

endmodule

// File: rtl/wave_voice_mixer.sv
// Multi-channel wavetable voice generator and saturating mixer.
// Define WAVE_ENV_DECAY_EN to add a per-channel release envelope.
module wave_voice_mixer
  import wave_pkg::*;
#(
  parameter  int unsigned NCH       = 4,
  parameter  int unsigned PHASE_W   = 16,
  parameter  int unsigned VOL_W     = 4,
  parameter  int unsigned DECAY_DIV = 8,
  localparam int unsigned CH_W      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_en,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [PHASE_W-1:0]  cfg_freq,
  input  logic [VOL_W-1:0]    cfg_vol,
  input  logic                cfg_key,
  output logic                busy,
  output logic signed [15:0]  sample_o,
  output logic                sample_valid,
  output logic                overrun
);

  localparam int unsigned PROD_W = WAVE_SMP_W + 1 + VOL_W;
  localparam int unsigned ACC_W  = WAVE_SMP_W + $clog2(NCH) + 1;

  wave_state_e              state_q, state_d;
  logic [CH_W-1:0]          ch_q, ch_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [PROD_W-1:0] prod_q, prod_d;
  logic                     busy_q, busy_d;
  logic signed [15:0]       sample_q, sample_d;
  logic                     valid_q, valid_d;
  logic                     overrun_q, overrun_d;

  logic [PHASE_W-1:0] phase_q [NCH];
  logic [PHASE_W-1:0] phase_d [NCH];
  logic [PHASE_W-1:0] freq_q  [NCH];
  logic [PHASE_W-1:0] freq_d  [NCH];
  logic [VOL_W-1:0]   vol_q   [NCH];
  logic [VOL_W-1:0]   vol_d   [NCH];
  logic [NCH-1:0]     key_q, key_d;

`ifdef WAVE_ENV_DECAY_EN
  localparam int unsigned DEC_W = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  logic [VOL_W-1:0] env_q [NCH];
  logic [VOL_W-1:0] env_d [NCH];
  logic [DEC_W-1:0] dec_q, dec_d;
`endif

  logic signed [WAVE_SMP_W-1:0] smp;
  logic [VOL_W-1:0]             gain;
  logic                         advance;

  wave_rom_string u_rom (
    .idx_i (phase_q[ch_q][PHASE_W-1 -: 6]),
    .smp_o (smp)
  );

  always_comb begin
`ifdef WAVE_ENV_DECAY_EN
    gain    = env_q[ch_q];
    advance = key_q[ch_q] | (env_q[ch_q] != '0);
`else
    gain    = key_q[ch_q] ? vol_q[ch_q] : '0;
    advance = key_q[ch_q];
`endif
  end

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    acc_d     = acc_q;
    prod_d    = prod_q;
    busy_d    = busy_q;
    sample_d  = sample_q;
    valid_d   = 1'b0;
    overrun_d = 1'b0;
    phase_d   = phase_q;
    freq_d    = freq_q;
    vol_d     = vol_q;
    key_d     = key_q;
`ifdef WAVE_ENV_DECAY_EN
    env_d     = env_q;
    dec_d     = dec_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (sample_en) begin
          acc_d   = '0;
          ch_d    = '0;
          busy_d  = 1'b1;
          state_d = StFetch;
        end
      end
      StFetch: begin
        prod_d  = PROD_W'(smp) * PROD_W'($signed({1'b0, gain}));
        state_d = StAcc;
      end
      StAcc: begin
        acc_d = acc_q + ACC_W'(prod_q >>> VOL_W);
        if (advance) begin
          phase_d[ch_q] = phase_q[ch_q] + freq_q[ch_q];
        end
        if (ch_q == CH_W'(NCH - 1)) begin
          state_d = StOut;
        end else begin
          ch_d    = ch_q + 1'b1;
          state_d = StFetch;
        end
      end
      StOut: begin
        sample_d = sat16(32'(acc_q));
        valid_d  = 1'b1;
        busy_d   = 1'b0;
        state_d  = StIdle;
`ifdef WAVE_ENV_DECAY_EN
        // Released channels fade one step every DECAY_DIV completed frames.
        if (dec_q == DEC_W'(DECAY_DIV - 1)) begin
          dec_d = '0;
          for (int i = 0; i < NCH; i++) begin
            if (!key_q[i] && env_q[i] != '0) begin
              env_d[i] = env_q[i] - 1'b1;
            end
          end
        end else begin
          dec_d = dec_q + 1'b1;
        end
`endif
      end
      default: state_d = StIdle;
    endcase

    if (sample_en && state_q != StIdle) begin
      overrun_d = 1'b1;
    end

    // Config writes land after any in-frame update, so a key-on restart wins.
    if (cfg_we && 32'(cfg_ch) < NCH) begin
      freq_d[cfg_ch] = cfg_freq;
      vol_d[cfg_ch]  = cfg_vol;
      key_d[cfg_ch]  = cfg_key;
      if (cfg_key) begin
        phase_d[cfg_ch] = '0;
`ifdef WAVE_ENV_DECAY_EN
        env_d[cfg_ch]   = cfg_vol;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      ch_q      <= '0;
      acc_q     <= '0;
      prod_q    <= '0;
      busy_q    <= 1'b0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      phase_q   <= '{default: '0};
      freq_q    <= '{default: '0};
      vol_q     <= '{default: '0};
      key_q     <= '0;
`ifdef WAVE_ENV_DECAY_EN
      env_q     <= '{default: '0};
      dec_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      acc_q     <= acc_d;
      prod_q    <= prod_d;
      busy_q    <= busy_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      phase_q   <= phase_d;
      freq_q    <= freq_d;
      vol_q     <= vol_d;
      key_q     <= key_d;
`ifdef WAVE_ENV_DECAY_EN
      env_q     <= env_d;
      dec_q     <= dec_d;
`endif
    end
  end

  assign busy         = busy_q;
  assign sample_o     = sample_q;
  assign sample_valid = valid_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_wave_voice_mixer.sv
// Directed, table-driven bench for wave_voice_mixer with hand-computed expected samples.
module tb_wave_voice_mixer;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               sample_en;
  logic               cfg_we;
  logic [1:0]         cfg_ch;
  logic [15:0]        cfg_freq;
  logic [3:0]         cfg_vol;
  logic               cfg_key;
  logic               busy;
  logic signed [15:0] sample_o;
  logic               sample_valid;
  logic               overrun;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wave_voice_mixer #(
    .NCH       (4),
    .PHASE_W   (16),
    .VOL_W     (4),
    .DECAY_DIV (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_en    (sample_en),
    .cfg_we       (cfg_we),
    .cfg_ch       (cfg_ch),
    .cfg_freq     (cfg_freq),
    .cfg_vol      (cfg_vol),
    .cfg_key      (cfg_key),
    .busy         (busy),
    .sample_o     (sample_o),
    .sample_valid (sample_valid),
    .overrun      (overrun)
  );

  typedef struct {
    logic [15:0] freq;
    logic [3:0]  vol;
    int          nch;
    int          frames;
    bit          mid_zero;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic write_cfg(input logic [1:0] ch, input logic [15:0] freq, input logic [3:0] vol,
                           input logic key);
    cfg_we   = 1'b1;
    cfg_ch   = ch;
    cfg_freq = freq;
    cfg_vol  = vol;
    cfg_key  = key;
    @(posedge clk);
    #1 cfg_we = 1'b0;
  endtask

  task automatic run_frame(output logic [15:0] smp, output int lat);
    sample_en = 1'b1;
    @(posedge clk);
    #1 sample_en = 1'b0;
    lat = 0;
    smp = '0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (sample_valid) begin
        lat = c;
        smp = sample_o;
        break;
      end
    end
    if (lat == 0) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout: got no sample_valid required within 40 cycles");
    end
  endtask

  // Starts a frame and raises a second sample_en so that edge T+at samples it.
  task automatic frame_with_extra(input int at, output logic [15:0] smp, output int vcnt,
                                  output int ocnt);
    sample_en = 1'b1;
    @(posedge clk);
    #1 sample_en = 1'b0;
    vcnt = 0;
    ocnt = 0;
    smp  = '0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) check("busy_in_frame", busy, 1);
      if (sample_valid) begin
        vcnt++;
        smp = sample_o;
      end
      if (overrun) ocnt++;
      sample_en = (c == at - 1);
    end
    sample_en = 1'b0;
  endtask

  logic [15:0] smp;
  int          lat;
  int          vcnt;
  int          ocnt;

  initial begin
    rst_n     = 1'b0;
    sample_en = 1'b0;
    cfg_we    = 1'b0;
    cfg_ch    = '0;
    cfg_freq  = '0;
    cfg_vol   = '0;
    cfg_key   = 1'b0;

    //            freq     vol  nch frm mid  expected
    vecs[0] = '{16'h0400, 4'd15, 1, 7, 1'b1, 16'h0221};
    vecs[1] = '{16'h5400, 4'd15, 4, 2, 1'b0, 16'h7FFF};
    vecs[2] = '{16'hC800, 4'd15, 4, 2, 1'b0, 16'h8000};
    vecs[3] = '{16'hFC00, 4'd15, 1, 2, 1'b0, 16'hFAFC};
    vecs[4] = '{16'h0400, 4'd8,  1, 7, 1'b1, 16'h0123};
    vecs[5] = '{16'h0400, 4'd15, 2, 7, 1'b1, 16'h0442};
    vecs[6] = '{16'h5400, 4'd15, 1, 2, 1'b0, 16'h25A2};
    vecs[7] = '{16'hC800, 4'd15, 1, 2, 1'b0, 16'hDF30};
    vecs[8] = '{16'hFC00, 4'd1,  1, 2, 1'b0, 16'hFFAA};

    do_reset();
    check("reset_sample_o", sample_o, 0);
    check("reset_busy", busy, 0);
    check("reset_valid", sample_valid, 0);
    check("reset_overrun", overrun, 0);

    for (int i = 0; i < 9; i++) begin
      do_reset();
      for (int c = 0; c < vecs[i].nch; c++) begin
        write_cfg(c[1:0], vecs[i].freq, vecs[i].vol, 1'b1);
      end
      for (int f = 1; f <= vecs[i].frames; f++) begin
        run_frame(smp, lat);
        check($sformatf("v%0d_f%0d_latency", i, f), lat, 9);
        if (f == vecs[i].frames) begin
          check($sformatf("v%0d_f%0d_sample", i, f), smp, vecs[i].exp);
        end else if (f == 1 || vecs[i].mid_zero) begin
          check($sformatf("v%0d_f%0d_zero", i, f), smp, 0);
        end
      end
    end

    // Overrun mid-frame, key-off, and overrun arriving in the OUT cycle.
    do_reset();
    write_cfg(2'd0, 16'h0400, 4'd15, 1'b1);
    for (int f = 1; f <= 7; f++) run_frame(smp, lat);
    check("pre_overrun_sample", smp, 16'h0221);
    frame_with_extra(3, smp, vcnt, ocnt);
    check("ovr3_valid_count", vcnt, 1);
    check("ovr3_overrun_count", ocnt, 1);
    check("ovr3_sample", smp, 16'h05B0);
    check("ovr3_busy_after", busy, 0);
    run_frame(smp, lat);
    check("post_overrun_sample", smp, 16'h098D);
    write_cfg(2'd0, 16'h0400, 4'd15, 1'b0);
    run_frame(smp, lat);
`ifdef WAVE_ENV_DECAY_EN
    check("keyoff_sample", smp, 16'h0D98);
`else
    check("keyoff_sample", smp, 16'h0000);
`endif
    frame_with_extra(9, smp, vcnt, ocnt);
    check("ovr_out_valid_count", vcnt, 1);
    check("ovr_out_overrun_count", ocnt, 1);
`ifdef WAVE_ENV_DECAY_EN
    check("ovr_out_sample", smp, 16'h1197);
`else
    check("ovr_out_sample", smp, 16'h0000);
`endif
    check("ovr_out_busy_after", busy, 0);

    // Rewriting key=1 restarts the phase at index 0.
    do_reset();
    write_cfg(2'd0, 16'h0400, 4'd15, 1'b1);
    for (int f = 1; f <= 7; f++) run_frame(smp, lat);
    check("rekey_pre_sample", smp, 16'h0221);
    write_cfg(2'd0, 16'h0400, 4'd15, 1'b1);
    run_frame(smp, lat);
    check("rekey_restart_sample", smp, 16'h0000);
    run_frame(smp, lat);
    check("rekey_second_sample", smp, 16'h0000);

    // Reset asserted while the FSM is in ACC.
    for (int f = 1; f <= 5; f++) run_frame(smp, lat);
    check("rst_pre_sample", smp, 16'h0221);
    sample_en = 1'b1;
    @(posedge clk);
    #1 sample_en = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_sample_o", sample_o, 0);
    check("rst_mid_valid", sample_valid, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    run_frame(smp, lat);
    check("rst_post_latency", lat, 9);
    check("rst_post_sample", smp, 16'h0000);
    run_frame(smp, lat);
    check("rst_post_sample2", smp, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
